// File: rtl/divide_unit_param_if.sv
// Purpose: operand/result/handshake bundle between the instruction-execute FSM
//          (master) and the EAE divider (slave).
// Signals: dividend (2*WIDTH, AC:MQ), divisor, start, abort  -> divider
//          quotient, remainder, link_out, busy, finished      <- divider
interface divide_unit_param_if #(
  parameter int unsigned WIDTH = 12
);
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0]   divisor;
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic               link_out;
  logic               busy;
  logic               finished;

  modport master (
    output dividend, divisor, start, abort,
    input  quotient, remainder, link_out, busy, finished
  );

  modport slave (
    input  dividend, divisor, start, abort,
    output quotient, remainder, link_out, busy, finished
  );
endinterface

// File: rtl/divide_unit_param.sv
// Purpose: unsigned restoring divider, 2*WIDTH-bit dividend (AC:MQ) by a
//          WIDTH-bit divisor, one quotient bit per clock. Overflow and
//          divide-by-zero are detected before any step and flagged on link_out.
// Ports:   clock  - rising-edge clock
//          reset  - asynchronous, active-high reset
//          bus    - slave side of divide_unit_param_if (operands, start/abort,
//                   quotient/remainder/link_out results, busy/finished status)
module divide_unit_param #(
  parameter int unsigned WIDTH = 12
) (
  input  logic               clock,
  input  logic               reset,
  divide_unit_param_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   trial_c;
  logic [WIDTH-1:0] r_next_c;
  logic [WIDTH-1:0] q_next_c;
  logic             reject_c;

  // One restoring step: shift MQ's top bit into R and try to subtract D.
  // R < D always holds, so a successful trial fits back into WIDTH bits.
  always_comb begin
    trial_c  = {r_q, q_q[WIDTH-1]} - {1'b0, d_q};
    r_next_c = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    q_next_c = {q_q[WIDTH-2:0], 1'b0};
    if (!trial_c[WIDTH]) begin
      r_next_c = trial_c[WIDTH-1:0];
      q_next_c = {q_q[WIDTH-2:0], 1'b1};
    end
  end

  // Quotient would not fit in WIDTH bits (or divisor is zero).
  assign reject_c = (bus.divisor == '0) ||
                    (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor);

  // State, working registers and result registers.
  // busy/finished are registered decodes of the current state, so they trail
  // the state by one edge and can never be high together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      r_q           <= '0;
      q_q           <= '0;
      d_q           <= '0;
      cnt           <= '0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.link_out  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.finished  <= 1'b0;
    end else begin
      bus.busy     <= (state == RUN);
      bus.finished <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            r_q <= bus.dividend[2*WIDTH-1:WIDTH];
            q_q <= bus.dividend[WIDTH-1:0];
            d_q <= bus.divisor;
            cnt <= '0;
            if (reject_c) begin
              // Operands are handed back untouched alongside the flag.
              state         <= DONE;
              bus.quotient  <= bus.dividend[WIDTH-1:0];
              bus.remainder <= bus.dividend[2*WIDTH-1:WIDTH];
              bus.link_out  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          // abort wins over completion and leaves the results untouched.
          if (bus.abort) begin
            state <= IDLE;
          end else begin
            r_q <= r_next_c;
            q_q <= q_next_c;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_STEP) begin
              state         <= DONE;
              bus.quotient  <= q_next_c;
              bus.remainder <= r_next_c;
              bus.link_out  <= 1'b0;
            end
          end
        end
        DONE: begin
          // A held start must not retrigger another divide.
          if (!bus.start) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_unit_param.sv
// Purpose: directed-vector scoreboard bench for divide_unit_param (WIDTH=12).
// Stimulus pushes the expected result of each accepted divide; a monitor pops
// and compares whenever finished rises, including latency and busy length.
module tb_divide_unit_param;

  localparam int unsigned W = 12;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         l;
    int           start_edge;
    int           lat;
    int           busy_len;
  } exp_t;

  logic clock;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  divide_unit_param_if #(.WIDTH(W)) bus ();

  divide_unit_param #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per rising edge of finished.
  initial begin
    logic fin_prev;
    logic busy_prev;
    int   busy_cnt;
    exp_t e;
    fin_prev  = 1'b0;
    busy_prev = 1'b0;
    busy_cnt  = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        fin_prev  = 1'b0;
        busy_prev = 1'b0;
        busy_cnt  = 0;
      end else begin
        check("busy_and_finished", 32'(bus.busy & bus.finished), 32'd0);
        if (bus.busy && !busy_prev) busy_cnt = 1;
        else if (bus.busy) busy_cnt = busy_cnt + 1;
        if (bus.finished && !fin_prev) begin
          if (sb.size() == 0) begin
            check("unexpected_finished", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("quotient", 32'(bus.quotient), 32'(e.q));
            check("remainder", 32'(bus.remainder), 32'(e.r));
            check("link_out", 32'(bus.link_out), 32'(e.l));
            check("latency", 32'(cyc - e.start_edge), 32'(e.lat));
            check("busy_cycles", 32'(busy_cnt), 32'(e.busy_len));
          end
          busy_cnt = 0;
        end
        fin_prev  = bus.finished;
        busy_prev = bus.busy;
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] r, input logic l);
    exp_t e;
    e.q          = q;
    e.r          = r;
    e.l          = l;
    e.start_edge = cyc + 1;
    e.lat        = l ? 1 : W + 1;
    e.busy_len   = l ? 0 : W;
    sb.push_back(e);
  endtask

  // Full divide: start, wait for finished, optionally hold start in DONE,
  // optionally drop and re-raise start while RUN is in progress.
  task automatic run_div(input logic [2*W-1:0] dvd, input logic [W-1:0] dsr,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic l,
                         input int hold, input bit toggle);
    bit got;
    got = 1'b0;
    @(negedge clock);
    bus.dividend = dvd;
    bus.divisor  = dsr;
    bus.start    = 1'b1;
    push_exp(q, r, l);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (toggle && i == 0) bus.start = 1'b0;
      if (toggle && i == 3) bus.start = 1'b1;
      if (bus.finished) begin
        got = 1'b1;
        break;
      end
    end
    check("finished_timeout", 32'(got), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check("finished_held", 32'(bus.finished), 32'd1);
    end
    bus.start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("idle_finished", 32'(bus.finished), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                               input logic l, input logic b, input logic f);
    check({tag, "_quotient"}, 32'(bus.quotient), 32'(q));
    check({tag, "_remainder"}, 32'(bus.remainder), 32'(r));
    check({tag, "_link"}, 32'(bus.link_out), 32'(l));
    check({tag, "_busy"}, 32'(bus.busy), 32'(b));
    check({tag, "_finished"}, 32'(bus.finished), 32'(f));
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_outputs("reset", 12'h000, 12'h000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    // Case 1: 100 / 7
    run_div(24'h000064, 12'h007, 12'h00E, 12'h002, 1'b0, 0, 1'b0);

    // Case 5a: abort in RUN cycle 5 keeps the previous result
    @(negedge clock);
    bus.dividend = 24'h000064;
    bus.divisor  = 12'h007;
    bus.start    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 0) bus.start = 1'b0;
      bus.abort = (i == 4);
    end
    bus.abort = 1'b0;
    for (int i = 0; i < 20; i++) @(negedge clock);
    check_outputs("abort", 12'h00E, 12'h002, 1'b0, 1'b0, 1'b0);

    // Case 2: 4096 / 2, start dropped and re-raised during RUN
    run_div(24'h001000, 12'h002, 12'h800, 12'h000, 1'b0, 0, 1'b1);

    // Case 3: overflow and divide-by-zero
    run_div(24'h005123, 12'h005, 12'h123, 12'h005, 1'b1, 0, 1'b0);
    run_div(24'h005123, 12'h000, 12'h123, 12'h005, 1'b1, 0, 1'b0);

    // Case 4: largest non-overflowing quotient, start held in DONE
    run_div(24'hFFEFFF, 12'hFFF, 12'hFFF, 12'hFFE, 1'b0, 5, 1'b0);

    // Case 5b: asynchronous reset between edges mid-RUN
    @(negedge clock);
    bus.dividend = 24'h001000;
    bus.divisor  = 12'h002;
    bus.start    = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_outputs("async_reset", 12'h000, 12'h000, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_outputs("post_reset", 12'h000, 12'h000, 1'b0, 1'b0, 1'b0);

    // Divider must be back in IDLE and accept a fresh divide
    run_div(24'h001000, 12'h002, 12'h800, 12'h000, 1'b0, 0, 1'b0);

    for (int i = 0; i < 5; i++) @(negedge clock);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divide_unit_param.md
Name: divide_unit_param

Overview:
Parametrised unsigned restoring divider for the EAE datapath: divides a 2*WIDTH-bit dividend (AC:MQ) by a WIDTH-bit divisor, one quotient bit per clock.
- Generalises the fixed 12-bit divider with a WIDTH parameter.
- Adds up-front divide-overflow and divide-by-zero detection reported on link_out.
- Adds busy/done handshake, synchronous abort, asynchronous reset and result registers that hold the last completed result.
- Sits between the instruction-execute FSM and the AC/MQ/link registers.

Parameters:
WIDTH, 12, word width. Dividend is 2*WIDTH; divisor, quotient and remainder are WIDTH. Must be >= 2.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
dividend  in  2*WIDTH  high half = AC, low half = MQ; sampled only on accepted start
divisor  in  WIDTH  sampled only on accepted start
start  in  1  level request; accepted only in IDLE
abort  in  1  synchronous cancel of an in-progress divide
quotient  out  WIDTH  last completed quotient (MQ)
remainder  out  WIDTH  last completed remainder (AC)
link_out  out  1  1 = overflow or divide-by-zero on last operation
busy  out  1  high in RUN
finished  out  1  high in DONE

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - quotient, remainder, link_out, busy and finished all go to 0.
  - Internal R/Q/D registers and the counter are cleared.
- States and transitions:
  - IDLE, start=1: load R = dividend[2W-1:W], Q = dividend[W-1:0], D = divisor, counter = 0.
    - If divisor == 0 or dividend[2W-1:W] >= divisor: go to DONE. Set link_out = 1, quotient = dividend[W-1:0], remainder = dividend[2W-1:W] (operands returned unchanged).
    - Otherwise go to RUN.
  - RUN: each edge performs one step and increments the counter.
    - Step: compute trial = {R, Q[W-1]} - {1'b0, D}, a (W+1)-bit value.
    - If trial[W] == 0: R = trial[W-1:0], Q = {Q[W-2:0], 1}.
    - Otherwise: R = {R[W-2:0], Q[W-1]}, Q = {Q[W-2:0], 0}.
    - On the edge performing step WIDTH (counter == WIDTH-1): go to DONE. quotient and remainder take the step-WIDTH results, link_out = 0.
  - RUN, abort=1: go to IDLE without performing the step. Output registers and link_out keep their prior values, and finished is not asserted. abort takes priority over completion.
  - DONE: finished = 1.
    - Stay in DONE while start = 1, so a held start never retriggers.
    - Go to IDLE on the first edge with start = 0.
  - abort is ignored in IDLE and DONE. start is ignored outside IDLE.
- Latency (start accepted at edge N):
  - Normal divide: finished first high after edge N+WIDTH+1. busy is high after edges N+1 through N+WIDTH.
  - Overflow or divide-by-zero: finished high after edge N+1; busy never asserts.
- Invariant: R < D at every step, so the trial result fits in WIDTH bits.
- Outputs:
  - quotient, remainder and link_out update only on entry to DONE; they are stable during RUN and IDLE.
  - busy and finished are decoded from state, never both high.
- Illegal state encodings recover to IDLE on the next edge.

Test Plan:
All cases use WIDTH=12.
1. dividend 24'h000064, divisor 12'h007, start held -> finished after edge N+13, quotient 12'h00E, remainder 12'h002, link_out 0, busy high 12 cycles.
2. dividend 24'h001000, divisor 12'h002 -> quotient 12'h800, remainder 12'h000, link_out 0.
3. Overflow and zero divisor:
   - dividend 24'h005123, divisor 12'h005 -> finished after edge N+1, busy never high, link_out 1, quotient 12'h123, remainder 12'h005.
   - Same dividend, divisor 0 -> identical response.
4. dividend 24'hFFEFFF, divisor 12'hFFF -> quotient 12'hFFF, remainder 12'hFFE, link_out 0.
5. Async reset and abort:
   - After a completed case-1 divide, start 24'h000064/12'h007 again, pulse abort in RUN cycle 5 -> IDLE, finished never high, outputs still 00E/002/0.
   - Assert reset mid-RUN between clock edges -> all outputs 0 immediately, IDLE.
6. Start handling:
   - Hold start high through DONE for 5 cycles -> finished stays high, no new divide.
   - Drop start -> IDLE next edge.
   - Start raised during RUN -> ignored.
